hps_reg_master: RTL and testbench
=================================

HPS_REG_MASTER -- requirements
Module: hps_reg_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hD070, the bus address of register offset 0.
REQ-002 SHALL have parameter GNT_TIMEOUT, default 8'd255, the maximum number of busy cycles waited before aborting.
REQ-003 Port clk, input, 1 bit: single clock for all logic.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port cmd_valid, input, 1 bit: HPS command present.
REQ-006 Port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-007 Port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 Port cmd_addr, input, 4 bits: starting register offset.
REQ-009 Port cmd_len, input, 3 bits: byte count; 1..4 are legal.
REQ-010 Port cmd_wdata, input, 32 bits: write bytes, little-endian, byte i in bits [8i+7:8i].
REQ-011 Port rsp_valid, output, 1 bit: response present.
REQ-012 Port rsp_ready, input, 1 bit: response consumed when high together with rsp_valid.
REQ-013 Port rsp_rdata, output, 32 bits: read bytes, little-endian; unread bytes are 0.
REQ-014 Port rsp_err, output, 1 bit: command rejected or timed out.
REQ-015 Port bus_addr, output, 16 bits: register bus address.
REQ-016 Port bus_dout, output, 8 bits: write data to the register block.
REQ-017 Port bus_din, input, 8 bits: combinational read data from the register block.
REQ-018 Port bus_we, output, 1 bit: write strobe.
REQ-019 Port bus_en, output, 1 bit: chip select.
REQ-020 Port cpu_busy, input, 1 bit: C64-side CPU currently owns the register bus.
REQ-021 Port bus_lock, output, 1 bit: high while the master owns the bus.

Function
REQ-022 SHALL implement the states IDLE, WAIT_GNT, ACCESS and RESP; all outputs SHALL be registered except cmd_ready.
REQ-023 cmd_ready SHALL equal (state == IDLE); a command SHALL be captured on the clock edge where cmd_valid and cmd_ready are both high.
REQ-024 When cmd_len is 0 or greater than 4, or cmd_addr + cmd_len > 16, the block SHALL go from IDLE directly to RESP with rsp_err=1 and rsp_rdata=0, and SHALL issue no bus cycle.
REQ-025 A legal command SHALL go from IDLE to WAIT_GNT and clear the timeout counter.
REQ-026 In WAIT_GNT:
- cpu_busy=0 -> ACCESS at the next edge.
- cpu_busy=1 -> the counter SHALL increment; on reaching GNT_TIMEOUT the block SHALL go to RESP with rsp_err=1 and no bus cycle.
REQ-027 ACCESS SHALL last exactly cmd_len consecutive cycles with bus_en=1 and bus_lock=1, and SHALL ignore cpu_busy, so that multi-byte access is atomic.
REQ-028 In ACCESS cycle i:
- bus_addr = BASE_ADDR + cmd_addr + i (16-bit add).
- bus_we = cmd_write.
- bus_dout = cmd_wdata[8i+7:8i] on writes, 0 on reads.
REQ-029 On reads, bus_din SHALL be sampled at the end of ACCESS cycle i into rsp_rdata[8i+7:8i].
REQ-030 Writes SHALL return rsp_rdata=0.
REQ-031 After the last ACCESS cycle, the next cycle SHALL show bus_en=0, bus_we=0, bus_lock=0, and state RESP with rsp_valid=1, rsp_err=0.
REQ-032 Outside ACCESS: bus_en=0, bus_we=0, bus_lock=0, bus_dout=0, and bus_addr held at its last value.
REQ-033 rsp_valid, rsp_rdata and rsp_err SHALL be held stable until the rsp_valid and rsp_ready handshake edge, then the block SHALL return to IDLE with rsp_valid=0.
REQ-034 A new command SHALL NOT be accepted in the same cycle as the response handshake.
REQ-035 Latency for a legal command with cpu_busy=0: accept at edge E0, WAIT_GNT in the cycle after E0, first bus_en in the cycle after E1, rsp_valid asserted after edge E(1+cmd_len).

Reset
REQ-036 With rst_n low at a clock edge, the following SHALL apply at that edge:
- state = IDLE;
- rsp_valid, rsp_err, bus_en, bus_we and bus_lock = 0;
- rsp_rdata = 0, bus_dout = 0, bus_addr = BASE_ADDR;
- timeout counter = 0.
REQ-037 A reset during ACCESS SHALL release the bus at that edge and discard the in-flight command with no response; cmd_ready SHALL be 1 in the first cycle after rst_n returns high.

Verification
REQ-038 Read, offset 5, len 4, cpu_busy=0, bus_din returns 0x40, 0x4B, 0x4C, 0x00 on successive ACCESS cycles -> bus_addr sequence D075..D078, rsp_rdata=0x004C4B40, rsp_err=0, rsp_valid after E5.
REQ-039 Write, offset 0, len 1, wdata 0x00000040 -> a single cycle with bus_addr=D070, bus_dout=0x40, bus_we=1, bus_en=1; then rsp_valid=1, rsp_rdata=0.
REQ-040 cpu_busy high for 10 cycles after accept, then low -> bus_en first asserted 1 cycle after cpu_busy falls, no error; raise cpu_busy mid-burst -> burst completes uninterrupted.
REQ-041 cpu_busy held high -> rsp_err=1 after 255 WAIT_GNT cycles, bus_en never asserted.
REQ-042 Offset 0xE with len 3, and separately len 0 and len 5 -> immediate rsp_err=1, rsp_valid one cycle after accept, no bus_en.
REQ-043 Reset asserted during the 2nd byte of a 4-byte read -> bus_en=0 after that edge, no rsp_valid, next command served normally; rsp_ready held low for 20 cycles -> response held stable, cmd_ready=0 throughout.

Source files
------------

// File: rtl/hps_reg_master_if.sv
// HPS command/response channel and register-bus signals of the register master.
// The master modport is the block's view; slave is the HPS plus register-block side.
interface hps_reg_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        bus_we;
  logic        bus_en;
  logic        cpu_busy;
  logic        bus_lock;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, rsp_ready, bus_din, cpu_busy,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_dout, bus_we, bus_en, bus_lock
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, rsp_ready, bus_din, cpu_busy,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_dout, bus_we, bus_en, bus_lock
  );
endinterface

// File: rtl/hps_reg_master.sv
// Byte-wide register-bus master serving 1..4 byte HPS read/write commands,
// arbitrating with the C64-side CPU and holding the bus for the whole burst.
module hps_reg_master #(
  parameter logic [15:0] BASE_ADDR   = 16'hD070,
  parameter logic [7:0]  GNT_TIMEOUT = 8'd255
) (
  input logic              clk,
  input logic              rst_n,
  hps_reg_master_if.master hps
);

  localparam int unsigned OFF_W  = 4;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BUS_AW = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    ACCESS,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [OFF_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [BUS_AW-1:0]   bus_addr_q, bus_addr_d;
  logic [BYTE_W-1:0]   bus_dout_q, bus_dout_d;
  logic                bus_we_q, bus_we_d;
  logic                bus_en_q, bus_en_d;
  logic                bus_lock_q, bus_lock_d;

  logic                cmd_legal;
  logic [OFF_W:0]      end_off;
  logic [CNT_W:0]      cnt_inc;
  logic [1:0]          idx_nx;
  logic                last_byte;

  // Command legality: 1..4 bytes that stay inside the 16-register window.
  always_comb begin
    end_off   = 5'(hps.cmd_addr) + 5'(hps.cmd_len);
    cmd_legal = (hps.cmd_len != 3'd0) && (hps.cmd_len <= 3'd4) && (end_off <= 5'd16);
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rdata_d     = rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_dout_d  = 8'd0;
    bus_we_d    = 1'b0;
    bus_en_d    = 1'b0;
    bus_lock_d  = 1'b0;
    cnt_inc     = 9'({1'b0, cnt_q}) + 9'd1;
    idx_nx      = idx_q + 2'd1;
    last_byte   = (3'({1'b0, idx_q}) == (len_q - 3'd1));

    unique case (state_q)
      IDLE: begin
        if (hps.cmd_valid) begin
          write_d = hps.cmd_write;
          addr_d  = hps.cmd_addr;
          len_d   = hps.cmd_len;
          wdata_d = hps.cmd_wdata;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
          rdata_d = 32'd0;
          if (cmd_legal) begin
            rsp_err_d = 1'b0;
            state_d   = WAIT_GNT;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end

      WAIT_GNT: begin
        if (!hps.cpu_busy) begin
          bus_en_d   = 1'b1;
          bus_lock_d = 1'b1;
          bus_we_d   = write_q;
          bus_addr_d = BASE_ADDR + 16'(addr_q);
          bus_dout_d = write_q ? wdata_q[7:0] : 8'd0;
          idx_d      = 2'd0;
          state_d    = ACCESS;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
          if (cnt_inc >= 9'({1'b0, GNT_TIMEOUT})) begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end

      // cpu_busy is deliberately ignored here so a multi-byte burst stays atomic.
      ACCESS: begin
        if (!write_q) begin
          rdata_d[{idx_q, 3'b000} +: BYTE_W] = hps.bus_din;
        end
        if (last_byte) begin
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          idx_d      = idx_nx;
          bus_en_d   = 1'b1;
          bus_lock_d = 1'b1;
          bus_we_d   = write_q;
          bus_addr_d = BASE_ADDR + 16'(addr_q) + 16'(idx_nx);
          bus_dout_d = write_q ? wdata_q[{idx_nx, 3'b000} +: BYTE_W] : 8'd0;
        end
      end

      RESP: begin
        if (hps.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      bus_addr_q  <= BASE_ADDR;
      bus_dout_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_en_q    <= 1'b0;
      bus_lock_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_dout_q  <= bus_dout_d;
      bus_we_q    <= bus_we_d;
      bus_en_q    <= bus_en_d;
      bus_lock_q  <= bus_lock_d;
    end
  end

  assign hps.cmd_ready = (state_q == IDLE);
  assign hps.rsp_valid = rsp_valid_q;
  assign hps.rsp_err   = rsp_err_q;
  assign hps.rsp_rdata = rdata_q;
  assign hps.bus_addr  = bus_addr_q;
  assign hps.bus_dout  = bus_dout_q;
  assign hps.bus_we    = bus_we_q;
  assign hps.bus_en    = bus_en_q;
  assign hps.bus_lock  = bus_lock_q;

endmodule

// File: tb/tb_hps_reg_master.sv
// Bench for hps_reg_master: directed vector table, hand-written reset/hold sequences
// and random commands, all checked against a transaction-level model of the register window.
module tb_hps_reg_master;

  localparam logic [15:0] BASE = 16'hD070;
  localparam int          TMO  = 255;

  typedef struct packed {
    logic [15:0] n;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  dout;
    logic        lock;
  } cyc_t;

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [2:0]  l;
    logic [31:0] wd;
    int          busy;
    bit          mid;
    int          hold;
    int          e_lat;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] regs  [16];
  logic [7:0] mregs [16];
  cyc_t       cyc_q[$];
  cyc_t       exp_q[$];
  vec_t       vecs[12];

  hps_reg_master_if ifc();

  hps_reg_master #(.BASE_ADDR(BASE), .GNT_TIMEOUT(8'd255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hps   (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      5: return 8'h40;
      6: return 8'h4B;
      7: return 8'h4C;
      8: return 8'h00;
      default: return 8'(i * 29 + 7);
    endcase
  endfunction

  // Register block: reset contents from init_val, combinational read data.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= init_val(i);
    end else if (ifc.bus_en && ifc.bus_we) begin
      regs[ifc.bus_addr[3:0]] <= ifc.bus_dout;
    end
  end
  assign ifc.bus_din = regs[ifc.bus_addr[3:0]];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic bit busy_at(input int n, input int busy, input bit mid);
    return mid ? ((n < busy) || (n >= busy + 2)) : (n < busy);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = init_val(i);
  endtask

  // Transaction model: latency counted in edges after the accept edge.
  task automatic model(input logic w, input logic [3:0] a, input logic [2:0] l, input logic [31:0] wd,
                       input int busy, input bit mid,
                       output int lat, output logic err, output logic [31:0] rd);
    int g;
    logic [7:0] d;
    exp_q.delete();
    rd  = 32'd0;
    err = 1'b0;
    if (l == 3'd0 || l > 3'd4 || int'(a) + int'(l) > 16) begin
      lat = 0;
      err = 1'b1;
      return;
    end
    g = -1;
    for (int n = 0; n < TMO; n++) begin
      if (!busy_at(n, busy, mid)) begin
        g = n;
        break;
      end
    end
    if (g < 0) begin
      lat = TMO;
      err = 1'b1;
      return;
    end
    for (int i = 0; i < int'(l); i++) begin
      if (w) begin
        d = wd[8*i +: 8];
        mregs[int'(a) + i] = d;
      end else begin
        d = 8'd0;
        rd[8*i +: 8] = mregs[int'(a) + i];
      end
      exp_q.push_back(cyc_t'{16'(g + 1 + i), BASE + 16'(int'(a) + i), w, d, 1'b1});
    end
    lat = g + 1 + int'(l);
  endtask

  task automatic run_cmd(input logic w, input logic [3:0] a, input logic [2:0] l, input logic [31:0] wd,
                         input int busy, input bit mid, input int hold,
                         output int lat, output logic err, output logic [31:0] rd);
    int          n;
    int          m_lat;
    logic        m_err;
    logic [31:0] m_rd;
    bit          noisy;
    model(w, a, l, wd, busy, mid, m_lat, m_err, m_rd);
    cyc_q.delete();
    noisy = 1'b0;
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = w;
    ifc.cmd_addr  = a;
    ifc.cmd_len   = l;
    ifc.cmd_wdata = wd;
    chk("cmd_ready_idle", 64'(ifc.cmd_ready), 64'd1);
    @(posedge clk);
    #1 ifc.cmd_valid = 1'b0;
    n   = 0;
    lat = -1;
    while (n < 400 && lat < 0) begin
      ifc.cpu_busy = busy_at(n, busy, mid);
      @(negedge clk);
      if (ifc.bus_en) cyc_q.push_back(cyc_t'{16'(n), ifc.bus_addr, ifc.bus_we, ifc.bus_dout, ifc.bus_lock});
      else if (ifc.bus_lock || ifc.bus_we || ifc.bus_dout != 8'd0) noisy = 1'b1;
      if (ifc.rsp_valid) lat = n;
      else begin
        @(posedge clk);
        #1 n++;
      end
    end
    err = ifc.rsp_err;
    rd  = ifc.rsp_rdata;
    chk("rsp_latency", 64'(lat), 64'(m_lat));
    chk("rsp_err", 64'(err), 64'(m_err));
    chk("rsp_rdata", 64'(rd), 64'(m_rd));
    chk("bus_idle_quiet", 64'(noisy), 64'd0);
    chk("bus_cycle_count", 64'(cyc_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < cyc_q.size() && i < exp_q.size(); i++)
      chk("bus_cycle", 64'(cyc_q[i]), 64'(exp_q[i]));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (!(ifc.rsp_valid === 1'b1 && ifc.rsp_rdata === rd && ifc.rsp_err === err && ifc.cmd_ready === 1'b0))
        chk("rsp_hold_stable", {ifc.rsp_valid, ifc.cmd_ready, ifc.rsp_err, ifc.rsp_rdata},
            {1'b1, 1'b0, err, rd});
    end
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1 ifc.rsp_ready = 1'b0;
    ifc.cpu_busy = 1'b0;
    @(negedge clk);
    chk("after_handshake", {ifc.rsp_valid, ifc.cmd_ready}, {1'b0, 1'b1});
  endtask

  initial begin
    int          lat;
    logic        err;
    logic [31:0] rd;

    ifc.cmd_valid = 1'b0;
    ifc.cmd_write = 1'b0;
    ifc.cmd_addr  = 4'd0;
    ifc.cmd_len   = 3'd0;
    ifc.cmd_wdata = 32'd0;
    ifc.rsp_ready = 1'b0;
    ifc.cpu_busy  = 1'b0;
    model_reset();

    vecs[0]  = '{1'b0, 4'd5,  3'd4, 32'h0,        0,   1'b0, 0,  5,   1'b0, 32'h004C4B40};
    vecs[1]  = '{1'b1, 4'd0,  3'd1, 32'h00000040, 0,   1'b0, 0,  2,   1'b0, 32'h0};
    vecs[2]  = '{1'b0, 4'd0,  3'd2, 32'h0,        10,  1'b0, 0,  13,  1'b0, 32'h00002440};
    vecs[3]  = '{1'b0, 4'd5,  3'd4, 32'h0,        0,   1'b1, 0,  5,   1'b0, 32'h004C4B40};
    vecs[4]  = '{1'b1, 4'hE,  3'd3, 32'h00123456, 0,   1'b0, 0,  0,   1'b1, 32'h0};
    vecs[5]  = '{1'b0, 4'd0,  3'd0, 32'h0,        0,   1'b0, 0,  0,   1'b1, 32'h0};
    vecs[6]  = '{1'b0, 4'd0,  3'd5, 32'h0,        0,   1'b0, 0,  0,   1'b1, 32'h0};
    vecs[7]  = '{1'b0, 4'hC,  3'd4, 32'h0,        0,   1'b0, 20, 5,   1'b0, 32'hBA9D8063};
    vecs[8]  = '{1'b1, 4'hD,  3'd3, 32'h00CCBBAA, 0,   1'b0, 1,  4,   1'b0, 32'h0};
    vecs[9]  = '{1'b0, 4'hD,  3'd3, 32'h0,        0,   1'b0, 0,  4,   1'b0, 32'h00CCBBAA};
    vecs[10] = '{1'b0, 4'd0,  3'd1, 32'h0,        300, 1'b0, 0,  255, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 4'hF,  3'd1, 32'h000000FF, 3,   1'b0, 0,  5,   1'b0, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_state",
        {ifc.cmd_ready, ifc.rsp_valid, ifc.rsp_err, ifc.bus_en, ifc.bus_we, ifc.bus_lock, ifc.bus_dout, ifc.bus_addr},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, BASE});
    chk("reset_rdata", 64'(ifc.rsp_rdata), 64'd0);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].w, vecs[i].a, vecs[i].l, vecs[i].wd, vecs[i].busy, vecs[i].mid, vecs[i].hold, lat, err, rd);
      chk("vec_latency", 64'(lat), 64'(vecs[i].e_lat));
      chk("vec_err", 64'(err), 64'(vecs[i].e_err));
      chk("vec_rdata", 64'(rd), 64'(vecs[i].e_rd));
    end

    // Reset in the middle of a 4-byte read: bus released, command dropped.
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = 1'b0;
    ifc.cmd_addr  = 4'd0;
    ifc.cmd_len   = 3'd4;
    @(posedge clk);
    #1 ifc.cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("second_byte_active", {ifc.bus_en, ifc.bus_lock, ifc.bus_addr}, {1'b1, 1'b1, BASE + 16'd1});
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_access",
        {ifc.bus_en, ifc.bus_lock, ifc.bus_we, ifc.rsp_valid, ifc.cmd_ready, ifc.bus_addr},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BASE});
    rst_n = 1'b1;
    model_reset();
    begin
      bit stray = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (ifc.rsp_valid || ifc.bus_en || !ifc.cmd_ready) stray = 1'b1;
      end
      chk("no_rsp_after_reset", 64'(stray), 64'd0);
    end
    run_cmd(1'b0, 4'd5, 3'd4, 32'h0, 0, 1'b0, 0, lat, err, rd);
    chk("post_reset_read", 64'(rd), 64'h004C4B40);

    for (int t = 0; t < 40; t++) begin
      logic        w;
      logic [3:0]  a;
      logic [2:0]  l;
      logic [31:0] wd;
      w  = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      l  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
      wd = 32'($urandom);
      run_cmd(w, a, l, wd, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), lat, err, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
